// File: rtl/mem_dump_tx.sv
// Streams a header byte, NumWords 32-bit memory words (LSB first) and a trailer byte over UART.
// Optional DUMP_CHECKSUM_EN inserts an XOR checksum of all data bytes before the trailer.
module mem_dump_tx #(
  parameter int unsigned Depth   = 1024,
  parameter int unsigned BaudDiv = 16,
  parameter logic [7:0]  HdrByte = 8'hAA,
  parameter logic [7:0]  TrlByte = 8'h55
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [15:0] NumWords,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        TX,
  output logic        Busy,
  output logic        Done
);

  localparam int unsigned   IdxW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [15:0]   BaudLast = 16'(BaudDiv - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(Depth - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_TRL,
`ifdef DUMP_CHECKSUM_EN
    S_FIN,
    S_CHK
`else
    S_FIN
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [9:0]      sh_q, sh_d;
  logic [15:0]     baud_q, baud_d;
  logic [3:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic [23:0]     data_q, data_d;
  logic [15:0]     words_q, words_d;
  logic [IdxW-1:0] idx_q, idx_d;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]      chk_q, chk_d;
`endif
  logic            tx_active;
  logic            byte_end;

  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  always_comb begin
    tx_active = (state_q == S_HDR) || (state_q == S_SEND) || (state_q == S_TRL);
`ifdef DUMP_CHECKSUM_EN
    if (state_q == S_CHK) tx_active = 1'b1;
`endif
  end

  assign byte_end = tx_active && (baud_q == BaudLast) && (bit_q == 4'd9);
  assign TX       = tx_active ? sh_q[0] : 1'b1;
  assign mem_req  = (state_q == S_REQ);
  assign mem_addr = 32'(idx_q) << 2;
  assign Busy     = (state_q != S_IDLE);
  assign Done     = (state_q == S_FIN);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    data_d  = data_q;
    words_d = words_q;
    idx_d   = idx_q;
`ifdef DUMP_CHECKSUM_EN
    chk_d   = chk_q;
`endif

    // Bit timing runs in every byte-sending state; a new frame loads on byte_end.
    if (tx_active) begin
      if (baud_q == BaudLast) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          bit_d = '0;
        end else begin
          bit_d = bit_q + 1'b1;
          sh_d  = {1'b1, sh_q[9:1]};
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_HDR;
          sh_d    = frame(HdrByte);
          words_d = NumWords;
          idx_d   = '0;
`ifdef DUMP_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      S_HDR: begin
        if (byte_end) begin
          if (words_q != 16'd0) begin
            state_d = S_REQ;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            state_d = S_CHK;
            sh_d    = frame(chk_q);
`else
            state_d = S_TRL;
            sh_d    = frame(TrlByte);
`endif
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_SEND;
          sh_d    = frame(mem_rdata[7:0]);
          data_d  = mem_rdata[31:8];
          byte_d  = '0;
          words_d = words_q - 1'b1;
          idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
`ifdef DUMP_CHECKSUM_EN
          chk_d   = chk_q ^ mem_rdata[7:0] ^ mem_rdata[15:8]
                          ^ mem_rdata[23:16] ^ mem_rdata[31:24];
`endif
        end
      end
      S_SEND: begin
        if (byte_end) begin
          if (byte_q != 2'd3) begin
            sh_d   = frame(data_q[7:0]);
            data_d = {8'h00, data_q[23:8]};
            byte_d = byte_q + 1'b1;
          end else if (words_q != 16'd0) begin
            state_d = S_REQ;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            state_d = S_CHK;
            sh_d    = frame(chk_q);
`else
            state_d = S_TRL;
            sh_d    = frame(TrlByte);
`endif
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_CHK: begin
        if (byte_end) begin
          state_d = S_TRL;
          sh_d    = frame(TrlByte);
        end
      end
`endif
      S_TRL: begin
        if (byte_end) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      sh_q    <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      data_q  <= '0;
      words_q <= '0;
      idx_q   <= '0;
`ifdef DUMP_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      words_q <= words_d;
      idx_q   <= idx_d;
`ifdef DUMP_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

endmodule
